data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter placed between the processor data port and `avalon_bus`. Master 0 is the processor data port; master 1 is a secondary requester (DMA/debug loader). The block grants the single data bus to one master at a time with round-robin fairness and forwards that master's read/write strobes, address and write data. It returns the slave's `DataDone` and read data to the granted master only, and aborts with an error if the slave does not respond within a bounded time.

## Interface
- `DATA_W`, 16, data width
- `ADDR_W`, 16, address width
- `TIMEOUT`, 255, cycles in BUSY before abort; 0 disables the watchdog

- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `M0Read`, `M1Read`  in  1  read request, held until matching Done
- `M0Write`, `M1Write`  in  1  write request, held until matching Done
- `M0Addr`, `M1Addr`  in  ADDR_W  request address
- `M0WrData`, `M1WrData`  in  DATA_W  write data
- `M0RdData`, `M1RdData`  out  DATA_W  captured read data, valid with Done
- `M0Done`, `M1Done`  out  1  one-cycle completion pulse
- `M0Err`, `M1Err`  out  1  one-cycle pulse coincident with Done on timeout
- `ReadData`, `WriteData`  out  1  slave strobes
- `DataAddr`  out  ADDR_W  slave address
- `DataOut`  out  DATA_W  slave write data
- `DataIn`  in  DATA_W  slave read data
- `DataDone`  in  1  slave completion

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - A master is requesting when its Read or Write is high.
  - With one requester, grant it.
  - With both requesting, grant the master that was not granted last. `last` resets to 1, so M0 wins the first tie.
  - On a grant, latch the master id, Addr, WrData and the op (Write has priority if both Read and Write are high), clear the watchdog, and go to BUSY.
- BUSY:
  - Drive `ReadData`/`WriteData`, `DataAddr` and `DataOut` from the latched values. Master inputs are not re-sampled.
  - On `DataDone`: capture `DataIn` into the granted master's RdData register (reads only) and go to DONE.
  - On watchdog reaching TIMEOUT (TIMEOUT≠0) without `DataDone`: set the err flag and go to DONE.
  - `DataDone` and timeout in the same cycle: `DataDone` wins and no Err is raised.
- DONE:
  - Slave strobes are low.
  - Pulse the granted master's Done, and its Err if flagged.
  - Update `last` to the granted id and return to IDLE.
- `DataDone` seen in IDLE or DONE is ignored.
- A master that drops its request during BUSY does not cancel the transaction. The cycle completes and Done still pulses.
- A master must deassert its request in the cycle after Done. A request still held in IDLE is treated as a new transaction.
- The watchdog counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it does not wrap.

## Timing
- Reset values, asynchronous on `Reset` low:
  - state = IDLE, `last` = 1, watchdog = 0.
  - All strobes, Done and Err outputs = 0.
  - `DataAddr`, `DataOut`, `M0RdData`, `M1RdData` = 0.
- Reset asserted mid-transaction drops the strobes immediately. No Done is issued.
- Request in IDLE at edge t:
  - Strobes high from t+1.
  - `DataDone` at edge t+k (k≥1) gives master Done at t+k+1.
  - Strobes are low from t+k+1.
- Minimum transaction: request to Done is 2 edges.
- Back-to-back transactions: at least one IDLE cycle between transactions, so strobes are low for ≥2 cycles between transactions.
- Timeout: strobes stay high for exactly TIMEOUT cycles; Done and Err pulse on the next cycle.
- All outputs are registered. There is no combinational path from master inputs or `DataDone` to any output.

## Structure
- Package `bus_pkg`:
  - `bus_state_t` enum (IDLE, BUSY, DONE).
  - `bus_op_t` (OP_READ, OP_WRITE).
  - `DATA_W`/`ADDR_W` default constants.
- One sub-module, `bus_watchdog`:
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT.
- Arbitration, latching and the FSM stay in the top.

## Test plan
- M0 read of 0x0040, slave asserts `DataDone` 3 cycles after the strobe with `DataIn`=0xBEEF -> `M0RdData`=0xBEEF, `M0Done` one cycle, `M1Done` stays 0.
- M0 and M1 both write in the same cycle from reset, both held through completion -> M0 served first, then M1. `DataAddr` sequence is M0Addr, M1Addr. Each Done fires exactly once.
- M0 requests continuously while M1 also requests -> grants alternate M0, M1, M0, M1 over 4 transactions; no starvation.
- TIMEOUT=4, slave never answers M1 read -> `ReadData` high exactly 4 cycles, then `M1Done`=`M1Err`=1 for one cycle, FSM back in IDLE.
- `DataDone` arriving on the same cycle the watchdog expires -> Done without Err, read data captured.
- `Reset` pulled low during BUSY -> strobes 0 immediately, no Done. After release, a fresh M1 request is granted normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default widths for the two-master data bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } bus_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } bus_op_t;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Arbiter-side bus bundle: two request ports plus the shared slave port.
// master = arbiter view (drives strobes and completions); slave = requesters and memory.
interface data_bus_arbiter_if #(
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int ADDR_W = bus_pkg::ADDR_W
);

  logic              M0Read;
  logic              M1Read;
  logic              M0Write;
  logic              M1Write;
  logic [ADDR_W-1:0] M0Addr;
  logic [ADDR_W-1:0] M1Addr;
  logic [DATA_W-1:0] M0WrData;
  logic [DATA_W-1:0] M1WrData;
  logic [DATA_W-1:0] M0RdData;
  logic [DATA_W-1:0] M1RdData;
  logic              M0Done;
  logic              M1Done;
  logic              M0Err;
  logic              M1Err;
  logic              ReadData;
  logic              WriteData;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] DataIn;
  logic              DataDone;

  modport master (
    input  M0Read, M1Read, M0Write, M1Write, M0Addr, M1Addr, M0WrData, M1WrData,
    input  DataIn, DataDone,
    output M0RdData, M1RdData, M0Done, M1Done, M0Err, M1Err,
    output ReadData, WriteData, DataAddr, DataOut
  );

  modport slave (
    output M0Read, M1Read, M0Write, M1Write, M0Addr, M1Addr, M0WrData, M1WrData,
    output DataIn, DataDone,
    input  M0RdData, M1RdData, M0Done, M1Done, M0Err, M1Err,
    input  ReadData, WriteData, DataAddr, DataOut
  );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating BUSY-cycle counter; expired is asserted combinationally on the cycle
// whose closing edge would bring the count to TIMEOUT. TIMEOUT = 0 never expires.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Firing one count early keeps the strobes high for exactly TIMEOUT cycles.
  assign expired = (TIMEOUT != 0) && enable && (cnt == LIMIT - CW'(1));

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin two-master arbiter for the data bus; request to Done is >= 2 edges, all outputs registered.
// Requests are held until Done; the slave stalls via DataDone, bounded by the watchdog.
module data_bus_arbiter #(
  parameter int DATA_W  = bus_pkg::DATA_W,
  parameter int ADDR_W  = bus_pkg::ADDR_W,
  parameter int TIMEOUT = 255
) (
  input logic                 Clock,
  input logic                 Reset,
  data_bus_arbiter_if.master  bus
);

  import bus_pkg::*;

  bus_state_t state;
  bus_state_t state_nx;
  bus_op_t    op;
  bus_op_t    op_nx;
  logic       last;
  logic       id;
  logic       gid;
  logic       start;
  logic       timeout;
  logic       expired;
  logic       req0;
  logic       req1;

  assign req0 = bus.M0Read | bus.M0Write;
  assign req1 = bus.M1Read | bus.M1Write;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    gid      = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start    = 1'b1;
          state_nx = BUSY;
          gid      = (req0 && req1) ? ~last : req1;
        end
      end
      BUSY: begin
        if (bus.DataDone) begin
          state_nx = DONE;
        end else if (expired) begin
          state_nx = DONE;
          timeout  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write wins when a master raises both strobes.
  always_comb begin
    op_nx = OP_READ;
    if (gid ? bus.M1Write : bus.M0Write) begin
      op_nx = OP_WRITE;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      id            <= 1'b0;
      op            <= OP_READ;
      bus.ReadData  <= 1'b0;
      bus.WriteData <= 1'b0;
      bus.DataAddr  <= '0;
      bus.DataOut   <= '0;
      bus.M0RdData  <= '0;
      bus.M1RdData  <= '0;
      bus.M0Done    <= 1'b0;
      bus.M1Done    <= 1'b0;
      bus.M0Err     <= 1'b0;
      bus.M1Err     <= 1'b0;
    end else begin
      state <= state_nx;

      if (start) begin
        id            <= gid;
        op            <= op_nx;
        bus.DataAddr  <= gid ? bus.M1Addr : bus.M0Addr;
        bus.DataOut   <= gid ? bus.M1WrData : bus.M0WrData;
        bus.ReadData  <= (op_nx == OP_READ);
        bus.WriteData <= (op_nx == OP_WRITE);
      end else if (state_nx != BUSY) begin
        bus.ReadData  <= 1'b0;
        bus.WriteData <= 1'b0;
      end

      if ((state == BUSY) && bus.DataDone && (op == OP_READ)) begin
        if (id) begin
          bus.M1RdData <= bus.DataIn;
        end else begin
          bus.M0RdData <= bus.DataIn;
        end
      end

      // Completion flags are registered on entry to DONE so they pulse during DONE.
      bus.M0Done <= (state_nx == DONE) && !id;
      bus.M1Done <= (state_nx == DONE) && id;
      bus.M0Err  <= timeout && !id;
      bus.M1Err  <= timeout && id;

      if (state == DONE) begin
        last <= id;
      end
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (start),
    .enable  (state == BUSY),
    .expired (expired)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a short watchdog (TIMEOUT = 4).
module tb_data_bus_arbiter;

  logic Clock;
  logic Reset;
  int   errors;
  int   checks;

  data_bus_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_bus_arbiter #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=simulation still running required=finished");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h required=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (!(bus.ReadData || bus.WriteData) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_strobe"}, 32'(bus.ReadData | bus.WriteData), 32'd1);
  endtask

  task automatic pulse_reset();
    #2 Reset = 1'b0;
    #2 Reset = 1'b1;
  endtask

  int strobe_cycles;

  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b0;
    bus.M0Read = 0;  bus.M1Read = 0;  bus.M0Write = 0;  bus.M1Write = 0;
    bus.M0Addr = 0;  bus.M1Addr = 0;  bus.M0WrData = 0; bus.M1WrData = 0;
    bus.DataIn = 0;  bus.DataDone = 0;

    // Reset state
    #23;
    chk("rst_rd",     32'(bus.ReadData),  32'd0);
    chk("rst_wr",     32'(bus.WriteData), 32'd0);
    chk("rst_addr",   32'(bus.DataAddr),  32'd0);
    chk("rst_dout",   32'(bus.DataOut),   32'd0);
    chk("rst_m0rd",   32'(bus.M0RdData),  32'd0);
    chk("rst_m1done", 32'(bus.M1Done),    32'd0);
    #4 Reset = 1'b1;
    tick();

    // M0 read of 0x0040, DataDone three cycles after the strobe
    bus.M0Read = 1; bus.M0Addr = 16'h0040;
    tick();
    chk("t1_rd_strobe", 32'(bus.ReadData),  32'd1);
    chk("t1_wr_strobe", 32'(bus.WriteData), 32'd0);
    chk("t1_addr",      32'(bus.DataAddr),  32'h0040);
    tick();
    tick();
    chk("t1_rd_held",   32'(bus.ReadData),  32'd1);
    bus.DataDone = 1; bus.DataIn = 16'hBEEF;
    tick();
    chk("t1_m0done",    32'(bus.M0Done),    32'd1);
    chk("t1_m1done",    32'(bus.M1Done),    32'd0);
    chk("t1_m0err",     32'(bus.M0Err),     32'd0);
    chk("t1_rddata",    32'(bus.M0RdData),  32'hBEEF);
    chk("t1_rd_low",    32'(bus.ReadData),  32'd0);
    bus.M0Read = 0; bus.DataDone = 0;
    tick();
    chk("t1_m0done_end", 32'(bus.M0Done),   32'd0);

    // Simultaneous writes straight out of reset: M0 first, then M1
    pulse_reset();
    tick();
    bus.M0Write = 1; bus.M0Addr = 16'h1000; bus.M0WrData = 16'hAAAA;
    bus.M1Write = 1; bus.M1Addr = 16'h2000; bus.M1WrData = 16'h5555;
    tick();
    chk("t2_wr0",     32'(bus.WriteData), 32'd1);
    chk("t2_addr0",   32'(bus.DataAddr),  32'h1000);
    chk("t2_dout0",   32'(bus.DataOut),   32'hAAAA);
    bus.DataDone = 1;
    tick();
    chk("t2_m0done",  32'(bus.M0Done),    32'd1);
    chk("t2_m1done0", 32'(bus.M1Done),    32'd0);
    bus.M0Write = 0; bus.DataDone = 0;
    tick();
    chk("t2_gap_wr",  32'(bus.WriteData), 32'd0);
    chk("t2_m0once",  32'(bus.M0Done),    32'd0);
    tick();
    chk("t2_wr1",     32'(bus.WriteData), 32'd1);
    chk("t2_addr1",   32'(bus.DataAddr),  32'h2000);
    chk("t2_dout1",   32'(bus.DataOut),   32'h5555);
    bus.DataDone = 1;
    tick();
    chk("t2_m1done",  32'(bus.M1Done),    32'd1);
    chk("t2_m0quiet", 32'(bus.M0Done),    32'd0);
    bus.M1Write = 0; bus.DataDone = 0;
    tick();
    chk("t2_m1once",  32'(bus.M1Done),    32'd0);

    // Both masters requesting continuously: grants alternate M0, M1, M0, M1
    bus.M0Read = 1; bus.M0Addr = 16'h00A0;
    bus.M1Read = 1; bus.M1Addr = 16'h00B0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe($sformatf("t3_%0d", i));
      chk($sformatf("t3_addr_%0d", i), 32'(bus.DataAddr), (i % 2 == 1) ? 32'h00B0 : 32'h00A0);
      bus.DataIn = 16'(16'h0100 + i); bus.DataDone = 1;
      tick();
      chk($sformatf("t3_m0done_%0d", i), 32'(bus.M0Done), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_m1done_%0d", i), 32'(bus.M1Done), (i % 2 == 1) ? 32'd1 : 32'd0);
      bus.DataDone = 0;
    end
    chk("t3_m1rd", 32'(bus.M1RdData), 32'h0103);
    chk("t3_m0rd", 32'(bus.M0RdData), 32'h0102);
    bus.M0Read = 0; bus.M1Read = 0;
    tick();
    tick();

    // Slave never answers an M1 read: four strobe cycles, then Done with Err
    bus.M1Read = 1; bus.M1Addr = 16'h0300;
    wait_strobe("t4");
    strobe_cycles = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!bus.ReadData) break;
      strobe_cycles++;
    end
    chk("t4_strobe_cycles", 32'(strobe_cycles), 32'd4);
    chk("t4_m1done", 32'(bus.M1Done), 32'd1);
    chk("t4_m1err",  32'(bus.M1Err),  32'd1);
    chk("t4_m0done", 32'(bus.M0Done), 32'd0);
    bus.M1Read = 0;
    tick();
    chk("t4_m1err_end",  32'(bus.M1Err),  32'd0);
    chk("t4_m1done_end", 32'(bus.M1Done), 32'd0);

    // DataDone on the same edge the watchdog expires: Done wins, no Err
    bus.M0Read = 1; bus.M0Addr = 16'h0500;
    wait_strobe("t5");
    tick();
    tick();
    tick();
    bus.DataDone = 1; bus.DataIn = 16'h1234;
    tick();
    chk("t5_m0done", 32'(bus.M0Done),   32'd1);
    chk("t5_m0err",  32'(bus.M0Err),    32'd0);
    chk("t5_rddata", 32'(bus.M0RdData), 32'h1234);
    bus.M0Read = 0; bus.DataDone = 0;
    tick();

    // Reset in the middle of a write: strobes drop at once, no Done afterwards
    bus.M0Write = 1; bus.M0Addr = 16'h0600; bus.M0WrData = 16'h6666;
    wait_strobe("t6");
    chk("t6_wr_before", 32'(bus.WriteData), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("t6_wr_async",   32'(bus.WriteData), 32'd0);
    chk("t6_addr_async", 32'(bus.DataAddr),  32'd0);
    #2 Reset = 1'b1;
    bus.M0Write = 0;
    tick();
    chk("t6_no_done_a", 32'(bus.M0Done), 32'd0);
    tick();
    chk("t6_no_done_b", 32'(bus.M0Done), 32'd0);
    bus.M1Read = 1; bus.M1Addr = 16'h0700;
    wait_strobe("t6_m1");
    chk("t6_m1_addr", 32'(bus.DataAddr), 32'h0700);
    chk("t6_m1_rd",   32'(bus.ReadData), 32'd1);
    bus.DataDone = 1; bus.DataIn = 16'hCAFE;
    tick();
    chk("t6_m1done", 32'(bus.M1Done),   32'd1);
    chk("t6_m1rd",   32'(bus.M1RdData), 32'hCAFE);
    bus.M1Read = 0; bus.DataDone = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
